// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_sub_bytes_seq (with helper Inverse_SBox)
// Purpose  : Time-multiplexed AES inverse SubBytes. LANES shared inverse
//            S-boxes walk the 16 state bytes over STEPS = 16/LANES cycles,
//            substituting in place inside a 128-bit working register.
//            Only one block is processed at a time.
// Ports    : clk, rst          - clock, async active-high reset
//            in_valid/in_ready - input handshake (ready only in IDLE)
//            data_in[127:0]    - input state, byte 0 = MSB
//            out_valid/out_ready - output handshake
//            data_out[127:0]   - substituted state, driven from register
//            busy              - high while in SUB or DONE
//            blk_count[15:0]   - completed-block counter, present only
//                                when INV_SUB_BYTES_SEQ_CNT_EN is defined
// Revision : 1.0 - initial release
// ============================================================================

module Inverse_SBox (
    input  logic [7:0] addr,
    output logic [7:0] dout
);
    // Row r holds inverse S-box entries 16r .. 16r+15, entry 0 at the MSB.
    localparam logic [2047:0] c_inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry a occupies bits 2047-8a down to 2040-8a; 2047-8a == {~a, 3'b111}.
    assign dout = c_inv_sbox[{~addr, 3'b111} -: 8];
endmodule

module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
`ifdef INV_SUB_BYTES_SEQ_CNT_EN
    ,
    output logic [15:0]  blk_count
`endif
);
    localparam int STEPS = 16 / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(STEPS - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_sub  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    logic [1:0]       r_fsm;
    logic [CNT_W-1:0] r_step;
    logic [127:0]     r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [7:0]       w_lane_addr [LANES];
    logic [7:0]       w_lane_dout [LANES];
    logic [127:0]     w_sub_state;

    // Byte b belongs to step b/LANES and is served by lane b%LANES.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            w_lane_addr[j] = 8'h00;
        end
        for (int b = 0; b < 16; b++) begin
            if (CNT_W'(b / LANES) == r_step) begin
                w_lane_addr[b % LANES] = r_state[127 - 8*b -: 8];
            end
        end
    end

    // Kept separate from the address mux so no false comb loop is formed
    // through the S-boxes.
    always_comb begin
        w_sub_state = r_state;
        for (int b = 0; b < 16; b++) begin
            if (CNT_W'(b / LANES) == r_step) begin
                w_sub_state[127 - 8*b -: 8] = w_lane_dout[b % LANES];
            end
        end
    end

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            Inverse_SBox u_sbox (
                .addr (w_lane_addr[j]),
                .dout (w_lane_dout[j])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= c_idle;
            r_step      <= '0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                c_idle: begin
                    if (in_valid) begin
                        r_state    <= data_in;
                        r_step     <= '0;
                        r_fsm      <= c_sub;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                c_sub: begin
                    r_state <= w_sub_state;
                    if (r_step == c_last_step) begin
                        // Counter holds on the last step so it never wraps
                        // inside a block; it is cleared on the next accept.
                        r_fsm       <= c_done;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                c_done: begin
                    // in_ready rises one cycle after the output handshake,
                    // so accept never overlaps delivery.
                    if (out_ready) begin
                        r_fsm       <= c_idle;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_fsm       <= c_idle;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign data_out  = r_state;

`ifdef INV_SUB_BYTES_SEQ_CNT_EN
    logic [15:0] r_blk_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk_count <= 16'h0000;
        end else if (r_out_valid && out_ready) begin
            r_blk_count <= r_blk_count + 16'd1;
        end
    end

    assign blk_count = r_blk_count;
`endif
endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_sub_bytes_seq
// Purpose  : Scoreboard bench for inv_sub_bytes_seq. Five instances
//            (LANES = 1, 2, 4, 8, 16) share one stimulus stream; the driver
//            pushes expected results, per-instance monitors pop and compare
//            data, latency and backpressure stability.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_sub_bytes_seq;
    localparam int N = 5;

    typedef struct {
        logic [127:0] data;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [127:0] data_in = '0;
    logic         out_ready = 1'b1;
    logic [N-1:0] in_ready_v;
    logic [N-1:0] out_valid_v;
    logic [N-1:0] busy_v;
    logic [127:0] data_out_v [N];
`ifdef INV_SUB_BYTES_SEQ_CNT_EN
    logic [15:0]  blk_count_v [N];
`endif

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q_exp [N][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < N; i++) begin : g_dut
        inv_sub_bytes_seq #(.LANES(1 << i)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[i]),
            .data_in   (data_in),
            .out_valid (out_valid_v[i]),
            .out_ready (out_ready),
            .data_out  (data_out_v[i]),
            .busy      (busy_v[i])
`ifdef INV_SUB_BYTES_SEQ_CNT_EN
            ,
            .blk_count (blk_count_v[i])
`endif
        );
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: one per instance, sampling on the falling edge.
    for (genvar i = 0; i < N; i++) begin : g_mon
        logic         prev_valid = 1'b0;
        logic         prev_ready = 1'b0;
        logic [127:0] prev_data  = '0;

        always @(negedge clk) begin
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid_v[i]) begin
                    chk($sformatf("busy_in_done_l%0d", 1 << i), {busy_v[i], in_ready_v[i]}, 2'b10);
                    if (!prev_valid) begin
                        if (q_exp[i].size() == 0) begin
                            chk($sformatf("unexpected_out_l%0d", 1 << i), 1, 0);
                        end else begin
                            chk($sformatf("latency_l%0d", 1 << i), 128'(cyc - q_exp[i][0].acc), 128'(16 >> i));
                        end
                    end else if (!prev_ready) begin
                        chk($sformatf("hold_data_l%0d", 1 << i), data_out_v[i], prev_data);
                    end
                    if (out_ready && q_exp[i].size() > 0) begin
                        chk($sformatf("data_l%0d", 1 << i), data_out_v[i], q_exp[i][0].data);
                        void'(q_exp[i].pop_front());
                    end
                end
                prev_valid = out_valid_v[i];
                prev_ready = out_ready;
                prev_data  = data_out_v[i];
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic [127:0] e);
        int t = 0;
        @(posedge clk); #2;
        while (in_ready_v != '1 && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        chk("send_ready", in_ready_v, {N{1'b1}});
        if (in_ready_v == '1) begin
            in_valid = 1'b1;
            data_in  = d;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) q_exp[i].push_back('{e, cyc});
            in_valid = 1'b0;
            data_in  = {4{32'hdeadbeef}};
        end
    endtask

    task automatic drain();
        int t = 0;
        int pend;
        do begin
            @(posedge clk); #2;
            pend = 0;
            for (int i = 0; i < N; i++) pend += q_exp[i].size();
            t++;
        end while (pend != 0 && t < 200);
        chk("drain", 128'(pend), 128'd0);
    endtask

    task automatic chk_idle(input string name);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_in_ready_l%0d", name, 1 << i), in_ready_v[i], 1'b1);
            chk($sformatf("%s_out_valid_l%0d", name, 1 << i), out_valid_v[i], 1'b0);
            chk($sformatf("%s_busy_l%0d", name, 1 << i), busy_v[i], 1'b0);
        end
    endtask

    localparam logic [127:0] c_c1_in  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    localparam logic [127:0] c_c1_out = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk_idle("reset");
        for (int i = 0; i < N; i++) chk($sformatf("reset_data_l%0d", 1 << i), data_out_v[i], 128'h0);
        rst = 1'b0;

        // 0x63 everywhere maps to zero
        send({16{8'h63}}, 128'h0);
        drain();

        // FIPS-197 C.1 round 1 vector
        send(c_c1_in, c_c1_out);
        drain();

        // Byte order: 00..0F
        send(128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb);
        drain();

        // Backpressure with ignored input pulses
        out_ready = 1'b0;
        send(c_c1_in, c_c1_out);
        repeat (20) begin @(posedge clk); #2; end
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            data_in  = '1;
            @(posedge clk); #2;
            chk("bp_in_ready", in_ready_v, '0);
            chk("bp_out_valid", out_valid_v, {N{1'b1}});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        send('1, {16{8'h7d}});
        drain();

        // Reset at step 2 of SUB (LANES=4 instance); wide lanes are in DONE
        out_ready = 1'b0;
        send(c_c1_in, c_c1_out);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_out_valid_l%0d", 1 << i), out_valid_v[i], 1'b0);
            chk($sformatf("rst_busy_l%0d", 1 << i), busy_v[i], 1'b0);
            q_exp[i].delete();
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;
        chk_idle("post_rst");
        out_ready = 1'b1;
        send(c_c1_in, c_c1_out);
        drain();

`ifdef INV_SUB_BYTES_SEQ_CNT_EN
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        send(c_c1_in, c_c1_out);
        send({16{8'h63}}, 128'h0);
        send('1, {16{8'h7d}});
        drain();
        for (int i = 0; i < N; i++) chk($sformatf("blk_count_l%0d", 1 << i), blk_count_v[i], 16'd3);
        @(negedge clk);
        force g_dut[2].u_dut.r_blk_count = 16'hffff;
        @(negedge clk);
        release g_dut[2].u_dut.r_blk_count;
        send(c_c1_in, c_c1_out);
        drain();
        chk("blk_count_wrap", blk_count_v[2], 16'h0000);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
